// File: rtl/fp8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp8_pkg
//  Description : Shared field layout and FSM encoding for the 8-bit float
//                format {sign, exp (bias 3), frac (hidden 1)}.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp8_pkg;

    localparam int EXP_W    = 3;
    localparam int FRAC_W   = 4;
    localparam int BIAS     = 3;
    localparam int EXP_MAX  = (1 << EXP_W) - 1;
    // Largest magnitude representable with exp = EXP_MAX and all-ones fraction
    localparam int MAXMAG   = (1 << (EXP_MAX - BIAS + 1)) - 1;

    localparam int SIGN_BIT = EXP_W + FRAC_W;
    localparam int EXP_MSB  = SIGN_BIT - 1;
    localparam int EXP_LSB  = FRAC_W;
    localparam int FRAC_MSB = FRAC_W - 1;
    localparam int FRAC_LSB = 0;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_ABS  = 2'd1;
    localparam logic [ST_W-1:0] ST_NORM = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/int2fp_if.sv
`default_nettype none
// ============================================================================
//  Module      : int2fp_if
//  Description : start/done handshake bundle for the integer-to-float converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface int2fp_if #(
    parameter int IN_W = 8
);
    logic            start;
    logic [IN_W-1:0] din;
    logic [7:0]      dout;
    logic            done;
    logic            busy;
    logic            ovf;

    modport master (
        output start, din,
        input  dout, done, busy, ovf
    );

    modport slave (
        input  start, din,
        output dout, done, busy, ovf
    );

endinterface
`default_nettype wire

// File: rtl/int2fp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int2fp_ctrl
//  Description : Controller FSM sequencing IDLE -> ABS -> NORM* -> DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module int2fp_ctrl
    import fp8_pkg::*;
(
    input  wire logic clk,
    input  wire logic clr,
    input  wire logic start,
    input  wire logic mant4,
    input  wire logic is_zero,
    input  wire logic is_ovf,
    output logic      ld_a,
    output logic      en_abs,
    output logic      en_norm,
    output logic      en_out,
    output logic      done,
    output logic      busy
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;

    always_ff @(posedge clk) begin
        if (clr) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_ABS;
            ST_ABS:  w_state_nxt = (is_zero || is_ovf) ? ST_DONE : ST_NORM;
            ST_NORM: if (mant4) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_a    = (r_state == ST_IDLE) && start;
        en_abs  = (r_state == ST_ABS);
        en_norm = (r_state == ST_NORM) && !mant4;
        en_out  = (r_state == ST_NORM) && mant4;
        done    = (r_state == ST_DONE);
        busy    = (r_state != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: rtl/int2fp.sv
`default_nettype none
// ============================================================================
//  Module      : int2fp
//  Description : Signed integer to fp8 converter, datapath plus controller,
//                normalising one left shift per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module int2fp
    import fp8_pkg::*;
#(
    parameter int IN_W = 8
) (
    input wire logic clk,
    input wire logic clr,
    int2fp_if.slave  bus
);

    localparam int              c_mant_w  = FRAC_W + 1;
    localparam logic [IN_W:0]   c_max_mag = (IN_W+1)'(MAXMAG);

    logic [IN_W-1:0]     r_a;
    logic                r_sign;
    logic [c_mant_w-1:0] r_mant;
    logic [EXP_W-1:0]    r_exp;
    logic [SIGN_BIT:0]   r_dout;
    logic                r_ovf;

    logic                w_sign;
    logic [IN_W:0]       w_a_ext;
    logic [IN_W:0]       w_mag;
    logic                w_is_zero;
    logic                w_is_ovf;
    logic                w_ld_a;
    logic                w_en_abs;
    logic                w_en_norm;
    logic                w_en_out;
    logic                w_done;
    logic                w_busy;

    // One extra bit so that negating the most negative input stays positive
    assign w_sign    = r_a[IN_W-1];
    assign w_a_ext   = {r_a[IN_W-1], r_a};
    assign w_mag     = w_sign ? ((~w_a_ext) + (IN_W+1)'(1)) : w_a_ext;
    assign w_is_zero = (w_mag == '0);
    assign w_is_ovf  = (w_mag > c_max_mag);

    int2fp_ctrl u_ctrl (
        .clk     (clk),
        .clr     (clr),
        .start   (bus.start),
        .mant4   (r_mant[c_mant_w-1]),
        .is_zero (w_is_zero),
        .is_ovf  (w_is_ovf),
        .ld_a    (w_ld_a),
        .en_abs  (w_en_abs),
        .en_norm (w_en_norm),
        .en_out  (w_en_out),
        .done    (w_done),
        .busy    (w_busy)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_a    <= '0;
            r_sign <= 1'b0;
            r_mant <= '0;
            r_exp  <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_ld_a) r_a <= bus.din;
            if (w_en_abs) begin
                r_sign <= w_sign;
                if (w_is_zero) begin
                    r_dout <= '0;
                    r_ovf  <= 1'b0;
                end else if (w_is_ovf) begin
                    r_dout <= {w_sign, {(EXP_W+FRAC_W){1'b1}}};
                    r_ovf  <= 1'b1;
                end else begin
                    r_mant <= w_mag[c_mant_w-1:0];
                    r_exp  <= EXP_W'(EXP_MAX);
                end
            end
            // Exponent starts at EXP_MAX and can fall at most FRAC_W steps
            if (w_en_norm) begin
                r_mant <= {r_mant[c_mant_w-2:0], 1'b0};
                r_exp  <= r_exp - EXP_W'(1);
            end
            if (w_en_out) begin
                r_dout <= {r_sign, r_exp, r_mant[FRAC_MSB:FRAC_LSB]};
                r_ovf  <= 1'b0;
            end
        end
    end

    assign bus.dout = r_dout;
    assign bus.ovf  = r_ovf;
    assign bus.done = w_done;
    assign bus.busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_int2fp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int2fp
//  Description : Directed and exhaustive checks of the int2fp converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int2fp;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_errors = 0;

    int2fp_if #(.IN_W(8)) bus ();

    int2fp #(.IN_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Independent reference: sign/magnitude, locate the leading one, pack.
    function automatic void ref_model(input logic [7:0] d, output logic [7:0] fo,
                                      output logic fovf, output int flat);
        int   a;
        int   m;
        int   p;
        int   k;
        int   e;
        int   fr;
        logic s;
        a = $signed(d);
        m = (a < 0) ? -a : a;
        s = d[7];
        p = 0;
        if (m == 0) begin
            fo = 8'h00; fovf = 1'b0; flat = 1;
        end else if (m > 31) begin
            fo = {s, 7'h7F}; fovf = 1'b1; flat = 1;
        end else begin
            for (int i = 0; i < 5; i++) if (((m >> i) & 1) == 1) p = i;
            k  = 4 - p;
            e  = 3 + p;
            fr = (m << k) & 15;
            fo = {s, e[2:0], fr[3:0]};
            fovf = 1'b0;
            flat = 2 + k;
        end
    endfunction

    task automatic convert(input logic [7:0] d, input logic [7:0] e_dout,
                           input logic e_ovf, input int e_lat, input string tag);
        int lat;
        @(negedge clk);
        bus.din   = d;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, " busy_at_accept"}, {31'd0, bus.busy}, 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.done && lat < 20);
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " dout"}, {24'd0, bus.dout}, {24'd0, e_dout});
        chk({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, e_ovf});
        chk({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " done_width"}, {31'd0, bus.done}, 32'd0);
        chk({tag, " busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] r_fo;
        logic       r_fovf;
        int         r_flat;
        int         lat;
        int         n_done;

        bus.start = 1'b0;
        bus.din   = 8'h00;
        clr       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", {24'd0, bus.dout}, 32'h00);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset ovf",  {31'd0, bus.ovf},  32'd0);
        clr = 1'b0;

        convert(8'h03, 8'h48, 1'b0, 5, "pos3");
        convert(8'hFB, 8'hD4, 1'b0, 4, "neg5");
        convert(8'h1F, 8'h7F, 1'b0, 2, "pos31");
        convert(8'hE1, 8'hFF, 1'b0, 2, "neg31");
        convert(8'h20, 8'h7F, 1'b1, 1, "pos32_ovf");
        convert(8'h80, 8'hFF, 1'b1, 1, "neg128_ovf");
        convert(8'h00, 8'h00, 1'b0, 1, "zero");
        convert(8'h01, 8'h30, 1'b0, 6, "one");

        // start raised in the DONE cycle is dropped
        @(negedge clk);
        bus.din = 8'h05; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bus.done && lat < 20);
        chk("done_start latency", lat, 4);
        bus.din = 8'h80; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("done_start busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_start still_idle", {31'd0, bus.busy}, 32'd0);
        chk("done_start dout", {24'd0, bus.dout}, 32'h54);

        // start pulsed during NORM is ignored
        @(negedge clk);
        bus.din = 8'h01; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.din = 8'h80; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 2;
        while (!bus.done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("norm_start latency", lat, 6);
        chk("norm_start dout", {24'd0, bus.dout}, 32'h30);
        chk("norm_start ovf", {31'd0, bus.ovf}, 32'd0);
        @(posedge clk);
        #1;

        // clr mid-NORM after an overflowed result
        convert(8'h80, 8'hFF, 1'b1, 1, "pre_clr");
        @(negedge clk);
        bus.din = 8'h01; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_norm dout_held", {24'd0, bus.dout}, 32'hFF);
        chk("mid_norm ovf_held", {31'd0, bus.ovf}, 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr dout", {24'd0, bus.dout}, 32'h00);
        chk("clr busy", {31'd0, bus.busy}, 32'd0);
        chk("clr ovf",  {31'd0, bus.ovf},  32'd0);
        n_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        chk("clr no_done", n_done, 0);

        for (int v = 0; v < 256; v++) begin
            logic [7:0] dv;
            dv = v[7:0];
            ref_model(dv, r_fo, r_fovf, r_flat);
            convert(dv, r_fo, r_fovf, r_flat, $sformatf("sweep_%02h", dv));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
